// File: rtl/game_pkg.sv
// Shared types and constants for the StickmanRun game sequencer.
package game_pkg;

   // Game sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      OVER  = 2'd2,
      ARMED = 2'd3
   } game_state_t;

   localparam logic [7:0] KEY_SPACE = 8'h2C;
   localparam logic [7:0] KEY_NONE  = 8'h00;

   // Four packed BCD digits, [15:12] is the thousands digit
   typedef logic [15:0] bcd4_t;

   // Single BCD digit increment with wrap from 9 to 0
   function automatic logic [3:0] bcd_digit_inc(input logic [3:0] d);
      return (d == 4'd9) ? 4'd0 : d + 4'd1;
   endfunction

endpackage

// File: rtl/game_controller_if.sv
// Signal bundle between the game sequencer and the rest of StickmanRun.
interface game_controller_if;
   import game_pkg::*;

   logic        frame_clk;
   logic [7:0]  keycode;
   logic        is_stickman;
   logic        is_obstacle;
   logic        playing;
   logic        game_over;
   bcd4_t       score;
   bcd4_t       high_score;
   logic [3:0]  speed;

   // Sequencer side
   modport master (
      input  frame_clk, keycode, is_stickman, is_obstacle,
      output playing, game_over, score, high_score, speed
   );

   // Surrounding design (video, keyboard, display) side
   modport slave (
      output frame_clk, keycode, is_stickman, is_obstacle,
      input  playing, game_over, score, high_score, speed
   );

endinterface

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter, saturating at 9999, with a pulse whenever an
// increment rolls the low two digits over to 00.
module bcd_counter4
   import game_pkg::*;
(
   input  logic  Clk,
   input  logic  Reset,
   input  logic  clear,
   input  logic  inc,
   output bcd4_t value,
   output logic  roll100
);

   bcd4_t      value_reg;
   bcd4_t      value_next;
   logic       roll100_reg;
   logic [3:0] is_nine;
   logic       at_max;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_digit
         assign is_nine[gi] = (value_reg[4*gi +: 4] == 4'd9);
      end
   endgenerate

   assign at_max = &is_nine;

   // Ripple the decimal carry: a digit steps only when every lower digit is 9
   always_comb begin
      logic carry;
      value_next = value_reg;
      carry      = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            value_next[4*i +: 4] = bcd_digit_inc(value_reg[4*i +: 4]);
         end
         carry = carry & is_nine[i];
      end
   end

   // Count register; clear wins over increment, increments stop at 9999
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         value_reg   <= '0;
         roll100_reg <= 1'b0;
      end else if (clear) begin
         value_reg   <= '0;
         roll100_reg <= 1'b0;
      end else if (inc && !at_max) begin
         value_reg   <= value_next;
         roll100_reg <= (value_reg[7:0] == 8'h99);
      end else begin
         roll100_reg <= 1'b0;
      end
   end

   assign value   = value_reg;
   assign roll100 = roll100_reg;

endmodule

// File: rtl/game_controller.sv
// StickmanRun game sequencer: state machine, frame tick, collision latch,
// score/high-score keeping and obstacle speed level.
module game_controller
   import game_pkg::*;
#(
   parameter int unsigned FRAMES_PER_POINT = 6,
   parameter int unsigned HOLD_FRAMES      = 60,
   parameter logic [3:0]  SPEED_INIT       = 4'd2,
   parameter logic [3:0]  SPEED_MAX        = 4'd8,
   parameter logic [7:0]  START_KEY        = KEY_SPACE
)
(
   input  logic              Clk,
   input  logic              Reset,
   game_controller_if.master bus
);

   localparam int FW = $clog2(FRAMES_PER_POINT + 1);
   localparam int HW = $clog2(HOLD_FRAMES + 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_POINT - 1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_FRAMES - 1);

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_RUN   = RUN;
   localparam logic [1:0] ST_OVER  = OVER;
   localparam logic [1:0] ST_ARMED = ARMED;

   logic          frame_clk_delayed_reg;
   logic          tick_reg;
   logic [1:0]    state_reg;
   logic          hit_flag_reg;
   logic [FW-1:0] frame_cnt_reg;
   logic [HW-1:0] hold_cnt_reg;
   logic [3:0]    speed_reg;
   bcd4_t         high_score_reg;

   bcd4_t         score_value;
   logic          score_roll100;
   logic          hit_now;
   logic          hit_any;
   logic          start_req;
   logic          in_run;
   logic          score_inc;

   assign in_run    = (state_reg == ST_RUN);
   assign hit_now   = bus.is_stickman & bus.is_obstacle;
   assign hit_any   = hit_flag_reg | hit_now;
   assign start_req = (bus.keycode == START_KEY) &&
                      ((state_reg == ST_IDLE) || (state_reg == ST_ARMED));
   // A collision on the tick freezes the score even if a point was due
   assign score_inc = in_run && tick_reg && !hit_any && (frame_cnt_reg == FRAME_LAST);

   bcd_counter4 u_score (
      .Clk     (Clk),
      .Reset   (Reset),
      .clear   (start_req),
      .inc     (score_inc),
      .value   (score_value),
      .roll100 (score_roll100)
   );

   // One-Clk tick on each rising edge of the frame clock level
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         frame_clk_delayed_reg <= 1'b0;
         tick_reg              <= 1'b0;
      end else begin
         frame_clk_delayed_reg <= bus.frame_clk;
         tick_reg              <= bus.frame_clk & ~frame_clk_delayed_reg;
      end
   end

   // Game FSM with collision latch, frame divider and game-over hold counter
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_reg     <= ST_IDLE;
         hit_flag_reg  <= 1'b0;
         frame_cnt_reg <= '0;
         hold_cnt_reg  <= '0;
      end else begin
         case (state_reg)
            ST_IDLE, ST_ARMED: begin
               hit_flag_reg <= 1'b0;
               if (start_req) begin
                  state_reg     <= ST_RUN;
                  frame_cnt_reg <= '0;
               end
            end
            ST_RUN: begin
               if (tick_reg) begin
                  if (hit_any) begin
                     state_reg    <= ST_OVER;
                     hit_flag_reg <= 1'b0;
                     hold_cnt_reg <= '0;
                  end else if (frame_cnt_reg == FRAME_LAST) begin
                     frame_cnt_reg <= '0;
                  end else begin
                     frame_cnt_reg <= frame_cnt_reg + 1'b1;
                  end
               end else if (hit_now) begin
                  hit_flag_reg <= 1'b1;
               end
            end
            ST_OVER: begin
               hit_flag_reg <= 1'b0;
               if (tick_reg) begin
                  if (hold_cnt_reg == HOLD_LAST) begin
                     // Require the start key to be released before re-arming
                     if (bus.keycode == KEY_NONE) begin
                        state_reg <= ST_ARMED;
                     end
                  end else begin
                     hold_cnt_reg <= hold_cnt_reg + 1'b1;
                  end
               end
            end
            default: begin
               state_reg    <= ST_IDLE;
               hit_flag_reg <= 1'b0;
            end
         endcase
      end
   end

   // Speed level: reload at game start, step on every hundred points
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         speed_reg <= SPEED_INIT;
      end else if (start_req) begin
         speed_reg <= SPEED_INIT;
      end else if (score_roll100 && (speed_reg < SPEED_MAX)) begin
         speed_reg <= speed_reg + 4'd1;
      end
   end

   // Best score, captured on the tick that ends a run
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         high_score_reg <= '0;
      end else if (in_run && tick_reg && hit_any && (score_value > high_score_reg)) begin
         high_score_reg <= score_value;
      end
   end

   assign bus.playing    = in_run;
   assign bus.game_over  = (state_reg == ST_OVER) || (state_reg == ST_ARMED);
   assign bus.score      = score_value;
   assign bus.high_score = high_score_reg;
   assign bus.speed      = speed_reg;

endmodule
